// File: rtl/conv_acc_relu_if.sv
// ---------------------------------------------------------------------------
// conv_acc_relu_if
//   Bus between the 3x3 PE multiplier array and the accumulate/ReLU stage.
//   master : drives clear, in_valid, conv00..conv08, ch_num, bias;
//            observes out_valid, out_data, busy.
//   slave  : the accumulator (conv_acc_relu).
// ---------------------------------------------------------------------------
interface conv_acc_relu_if #(
  parameter int PROD_W = 25,
  parameter int BIAS_W = 32,
  parameter int CH_W   = 10
);
  logic                     clear;
  logic                     in_valid;
  logic signed [PROD_W-1:0] conv00, conv01, conv02;
  logic signed [PROD_W-1:0] conv03, conv04, conv05;
  logic signed [PROD_W-1:0] conv06, conv07, conv08;
  logic        [CH_W-1:0]   ch_num;
  logic signed [BIAS_W-1:0] bias;
  logic                     out_valid;
  logic signed [8:0]        out_data;
  logic                     busy;

  modport master (
    output clear, in_valid,
    output conv00, conv01, conv02, conv03, conv04, conv05, conv06, conv07, conv08,
    output ch_num, bias,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  clear, in_valid,
    input  conv00, conv01, conv02, conv03, conv04, conv05, conv06, conv07, conv08,
    input  ch_num, bias,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_acc_relu.sv
// ---------------------------------------------------------------------------
// conv_acc_relu
//   Reduces the nine tap products of one input channel through a two-stage
//   adder tree, accumulates across ch_num input channels, then adds the bias,
//   rescales with round-half-up, applies ReLU and saturates to 0..255.
//   Four register stages: S1 partial sums, S2 tree sum, S3 accumulate/final,
//   S4 output. No backpressure; every in_valid beat is taken.
//
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : conv_acc_relu_if.slave (clear, in_valid, conv00..08, ch_num,
//           bias in; out_valid, out_data, busy out)
// ---------------------------------------------------------------------------
module conv_acc_relu #(
  parameter int PROD_W = 25,
  parameter int ACC_W  = 40,
  parameter int BIAS_W = 32,
  parameter int SHIFT  = 8,
  parameter int CH_W   = 10
) (
  input  logic           clk,
  input  logic           reset,
  conv_acc_relu_if.slave bus
);

  localparam int PS_W = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] OUT_MIN = '0;

  // -------------------------------------------------------------------------
  // Channel counter and per-pixel parameter capture
  // -------------------------------------------------------------------------
  logic        [CH_W-1:0]   cnt;
  logic        [CH_W-1:0]   ch_hold;
  logic signed [BIAS_W-1:0] bias_hold;
  logic        [CH_W-1:0]   eff_ch;
  logic        [CH_W-1:0]   last_idx;
  logic signed [BIAS_W-1:0] pix_bias;
  logic                     in_last;
  logic                     beat;

  // The first beat of a pixel uses the live ch_num/bias (they are being
  // captured on that same edge); later beats use the held copies.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    eff_ch   = ch_hold;
    pix_bias = bias_hold;
    if (cnt == '0) begin
      eff_ch   = bus.ch_num;
      pix_bias = bus.bias;
    end
    last_idx = (eff_ch == '0) ? '0 : eff_ch - CH_W'(1);
    in_last  = (cnt == last_idx);
    beat     = bus.in_valid && !bus.clear;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      ch_hold   <= '0;
      bias_hold <= '0;
    end else if (bus.clear) begin
      cnt <= '0;
    end else if (bus.in_valid) begin
      if (cnt == '0) begin
        ch_hold   <= bus.ch_num;
        bias_hold <= bus.bias;
      end
      cnt <= in_last ? '0 : cnt + CH_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // S1: three partial sums of three taps each. The pixel bias rides along
  // with the data so a following pixel can capture its own bias meanwhile.
  // -------------------------------------------------------------------------
  logic                     s1_v, s1_last;
  logic signed [PS_W-1:0]   s1_p0, s1_p1, s1_p2;
  logic signed [BIAS_W-1:0] s1_bias;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_p0   <= '0;
      s1_p1   <= '0;
      s1_p2   <= '0;
      s1_bias <= '0;
    end else begin
      s1_v <= beat;
      if (beat) begin
        s1_last <= in_last;
        s1_bias <= pix_bias;
        s1_p0   <= PS_W'(bus.conv00) + PS_W'(bus.conv01) + PS_W'(bus.conv02);
        s1_p1   <= PS_W'(bus.conv03) + PS_W'(bus.conv04) + PS_W'(bus.conv05);
        s1_p2   <= PS_W'(bus.conv06) + PS_W'(bus.conv07) + PS_W'(bus.conv08);
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2: full tap sum at accumulator width
  // -------------------------------------------------------------------------
  logic                     s2_v, s2_last;
  logic signed [ACC_W-1:0]  s2_sum;
  logic signed [BIAS_W-1:0] s2_bias;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_sum  <= '0;
      s2_bias <= '0;
    end else begin
      s2_v <= s1_v && !bus.clear;
      if (s1_v) begin
        s2_last <= s1_last;
        s2_bias <= s1_bias;
        s2_sum  <= ACC_W'(s1_p0) + ACC_W'(s1_p1) + ACC_W'(s1_p2);
      end
    end
  end

  // -------------------------------------------------------------------------
  // S3: channel accumulation. The last channel folds in the bias and restarts
  // the accumulator on the same edge, so back-to-back pixels need no bubble.
  // -------------------------------------------------------------------------
  logic                    s3_v;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s3_final;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_v     <= 1'b0;
      acc      <= '0;
      s3_final <= '0;
    end else if (bus.clear) begin
      s3_v <= 1'b0;
      acc  <= '0;
    end else begin
      s3_v <= s2_v && s2_last;
      if (s2_v) begin
        if (s2_last) begin
          s3_final <= acc + s2_sum + ACC_W'(s2_bias);
          acc      <= '0;
        end else begin
          acc <= acc + s2_sum;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // S4: round half up, arithmetic rescale, ReLU and saturate to 0..255
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] rounded;
  logic signed [8:0]       clamped;

  always_comb begin
    rounded = (s3_final + RND) >>> SHIFT;
    clamped = rounded[8:0];
    if (rounded < OUT_MIN) begin
      clamped = '0;
    end else if (rounded > OUT_MAX) begin
      clamped = 9'sd255;
    end
  end

  logic              out_valid_q;
  logic signed [8:0] out_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s3_v && !bus.clear;
      if (s3_v && !bus.clear) begin
        out_data_q <= clamped;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (cnt != '0) || s1_v || s2_v || s3_v || out_valid_q;

endmodule

// File: tb/tb_conv_acc_relu.sv
module tb_conv_acc_relu;
  localparam int PROD_W = 25;
  localparam int ACC_W  = 40;
  localparam int BIAS_W = 32;
  localparam int SHIFT  = 8;
  localparam int CH_W   = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_acc_relu_if #(.PROD_W(PROD_W), .BIAS_W(BIAS_W), .CH_W(CH_W)) bus ();

  conv_acc_relu #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .SHIFT(SHIFT), .CH_W(CH_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed output log (written by the scoreboard only)
  int out_count    = 0;
  int last_out_val = 0;
  int last_out_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: whole-pixel arithmetic on plain integers
  // -------------------------------------------------------------------------
  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t   exp_q[$];
  longint m_sum  = 0;
  longint m_bias = 0;
  int     m_cnt  = 0;
  int     m_n    = 1;

  function automatic int ref_act(input longint total);
    longint r;
    r = (total + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  function automatic longint tap_sum();
    return longint'(bus.conv00) + longint'(bus.conv01) + longint'(bus.conv02)
         + longint'(bus.conv03) + longint'(bus.conv04) + longint'(bus.conv05)
         + longint'(bus.conv06) + longint'(bus.conv07) + longint'(bus.conv08);
  endfunction

  // Model updates on rising edges (inputs are stable then); outputs are
  // compared on falling edges. A pixel whose last beat is taken on edge k
  // is expected on edge k+3 after the taking edge, i.e. 4 edges in all.
  always @(clk) begin
    if (clk) begin
      cyc++;
      if (reset || bus.clear) begin
        m_cnt = 0;
        m_sum = 0;
        exp_q.delete();
      end else if (bus.in_valid) begin
        if (m_cnt == 0) begin
          m_n    = (bus.ch_num == '0) ? 1 : int'(bus.ch_num);
          m_bias = longint'(bus.bias);
        end
        m_sum += tap_sum();
        m_cnt++;
        if (m_cnt == m_n) begin
          exp_q.push_back('{ref_act(m_sum + m_bias), cyc + 3});
          m_cnt = 0;
          m_sum = 0;
        end
      end
    end else begin
      if (reset) begin
        m_cnt = 0;
        m_sum = 0;
        exp_q.delete();
        check("sb_reset_out_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        out_count++;
        last_out_val = int'(bus.out_data);
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out_valid", bus.out_valid, 0);
        end else begin
          check("sb_out_data", bus.out_data, exp_q[0].val);
          check("sb_out_cycle", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("sb_missing_out_valid", bus.out_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set_tap(input int i, input longint t);
    case (i)
      0: bus.conv00 = PROD_W'(t);
      1: bus.conv01 = PROD_W'(t);
      2: bus.conv02 = PROD_W'(t);
      3: bus.conv03 = PROD_W'(t);
      4: bus.conv04 = PROD_W'(t);
      5: bus.conv05 = PROD_W'(t);
      6: bus.conv06 = PROD_W'(t);
      7: bus.conv07 = PROD_W'(t);
      default: bus.conv08 = PROD_W'(t);
    endcase
  endtask

  task automatic set_all(input longint t);
    for (int i = 0; i < 9; i++) set_tap(i, t);
  endtask

  // Drive one beat at a falling edge; returns the edge count that takes it.
  task automatic drive_beat(input int ch, input longint b, input longint t, output int take_edge);
    @(negedge clk);
    bus.ch_num   = CH_W'(ch);
    bus.bias     = BIAS_W'(b);
    set_all(t);
    bus.in_valid = 1'b1;
    take_edge    = cyc + 1;
  endtask

  typedef struct {
    int     ch;
    longint bias;
    longint tap;
    int     beats;
    int     gap;
    int     exp_out;
    int     exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int c0;
    int last_edge;
    int eff;
    c0  = out_count;
    eff = (v.ch == 0) ? 1 : v.ch;
    for (int b = 0; b < v.beats; b++) begin
      drive_beat(v.ch, v.bias, v.tap, last_edge);
      if (b != v.beats - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          if (((b + 1) % eff) != 0)
            check($sformatf("vec%0d_busy_in_gap", idx), bus.busy, 1);
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check($sformatf("vec%0d_out_count", idx), out_count - c0, v.exp_cnt);
    check($sformatf("vec%0d_out_data", idx), last_out_val, v.exp_out);
    check($sformatf("vec%0d_latency", idx), last_out_cyc - last_edge, 3);
    check($sformatf("vec%0d_idle_busy", idx), bus.busy, 0);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    int c0;
    int e;

    //           ch  bias  tap       beats gap out cnt
    vecs[0] = '{1,   0,    100,      1,    0,  4,  1};
    vecs[1] = '{3,   256,  256,      3,    0,  28, 1};
    vecs[2] = '{1,   0,    -1000,    1,    0,  0,  1};
    vecs[3] = '{1,   0,    1 << 20,  1,    0,  255,1};
    vecs[4] = '{2,   0,    128,      2,    5,  9,  1};
    vecs[5] = '{2,   0,    128,      10,   0,  9,  5};
    vecs[6] = '{0,   -100, 50,       1,    0,  1,  1};

    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.ch_num   = '0;
    bus.bias     = '0;
    set_all(0);

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_busy", bus.busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // clear after two beats; the beat presented with clear is dropped
    c0 = out_count;
    drive_beat(4, 0, 1000, e);
    drive_beat(4, 0, 1000, e);
    drive_beat(4, 0, 1000, e);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_busy_after_clear", bus.busy, 0);
    for (int b = 0; b < 4; b++) drive_beat(4, 0, 10, e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("clr_out_count", out_count - c0, 1);
    check("clr_out_data", last_out_val, 1);
    check("clr_latency", last_out_cyc - e, 3);

    // clear while a finished pixel is still in the pipeline
    c0 = out_count;
    drive_beat(1, 0, 100, e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (8) @(negedge clk);
    check("clr_inflight_out_count", out_count - c0, 0);

    // asynchronous reset mid-cycle with a pixel in flight
    c0 = out_count;
    drive_beat(2, 0, 100, e);
    drive_beat(2, 0, 100, e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_out_valid", bus.out_valid, 0);
    check("rst_async_out_data", bus.out_data, 0);
    check("rst_async_busy", bus.busy, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_async_out_count", out_count - c0, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(9) < 7);
      bus.clear    = ($urandom_range(59) == 0);
      bus.ch_num   = CH_W'($urandom_range(4));
      bus.bias     = BIAS_W'(longint'($urandom_range(131072)) - 65536);
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(15) == 0)
          set_tap(i, ($urandom_range(1) == 0) ? longint'(16777215) : -longint'(16777216));
        else
          set_tap(i, longint'($urandom_range(8000)) - 4000);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (8) @(negedge clk);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_idle_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
